// File: rtl/dm_arb_pkg.sv
// Shared types and default widths for the data-memory arbiter.
package dm_arb_pkg;

  localparam int DM_ADDR_W = 10;
  localparam int DM_DATA_W = 32;

  typedef enum logic {
    FREE     = 1'b0,
    DMA_LOCK = 1'b1
  } arb_state_e;

  typedef enum logic {
    REQ_CPU = 1'b0,
    REQ_DMA = 1'b1
  } req_id_e;

endpackage

// File: rtl/dm_arbiter_if.sv
// Requester, return and memory pins of the data-memory arbiter.
// The arbiter takes the slave view; the CPU/DMA/memory side takes the master view.
interface dm_arbiter_if
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W = DM_ADDR_W,
  parameter int DATA_W = DM_DATA_W
);
  logic              cpu_req;
  logic              cpu_we;
  logic [ADDR_W-1:0] cpu_addr;
  logic [DATA_W-1:0] cpu_wdata;
  logic              cpu_gnt;
  logic              cpu_rvalid;
  logic [DATA_W-1:0] cpu_rdata;
  logic              dma_req;
  logic              dma_we;
  logic [ADDR_W-1:0] dma_addr;
  logic [DATA_W-1:0] dma_wdata;
  logic              dma_last;
  logic              dma_gnt;
  logic              dma_rvalid;
  logic [DATA_W-1:0] dma_rdata;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  modport slave (
    input  cpu_req, cpu_we, cpu_addr, cpu_wdata,
    input  dma_req, dma_we, dma_addr, dma_wdata, dma_last,
    input  mem_rdata,
    output cpu_gnt, cpu_rvalid, cpu_rdata,
    output dma_gnt, dma_rvalid, dma_rdata,
    output mem_we, mem_addr, mem_wdata
  );

  modport master (
    output cpu_req, cpu_we, cpu_addr, cpu_wdata,
    output dma_req, dma_we, dma_addr, dma_wdata, dma_last,
    output mem_rdata,
    input  cpu_gnt, cpu_rvalid, cpu_rdata,
    input  dma_gnt, dma_rvalid, dma_rdata,
    input  mem_we, mem_addr, mem_wdata
  );

endinterface

// File: rtl/dm_arb_rr_pick.sv
// Two-way grant picker: a lone requester wins, ties go to the pointer (round-robin).
// Build option DM_ARB_CPU_PRIORITY_EN: ties always go to the CPU and the pointer is ignored.
module dm_arb_rr_pick
  import dm_arb_pkg::*;
(
  input  logic [1:0] i_req,
  input  req_id_e    i_ptr,
  output logic [1:0] o_gnt
);

`ifdef DM_ARB_CPU_PRIORITY_EN
  logic w_unused_ptr;
  assign w_unused_ptr = i_ptr;

  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) o_gnt = 2'b01;
  end
`else
  always_comb begin
    o_gnt = i_req;
    if (i_req == 2'b11) o_gnt = (i_ptr == REQ_CPU) ? 2'b01 : 2'b10;
  end
`endif

endmodule

// File: rtl/dm_arbiter.sv
// Data-memory arbiter: CPU single beats vs DMA bursts with a burst lock, 1-cycle read return.
// Build option DM_ARB_CPU_PRIORITY_EN: FREE-state ties go to the CPU instead of round-robin.
module dm_arbiter
  import dm_arb_pkg::*;
#(
  parameter int ADDR_W    = DM_ADDR_W,
  parameter int DATA_W    = DM_DATA_W,
  parameter int MAX_BURST = 16
) (
  input logic         clk,
  input logic         rst_n,
  dm_arbiter_if.slave bus
);

  localparam int               CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MAX_BURST - 1);
  localparam bit               BURST_EN = (MAX_BURST > 1);

  arb_state_e        r_state;
  logic [CNT_W-1:0]  r_beat_cnt;
  req_id_e           r_rr_ptr;
  logic              r_cpu_rvalid;
  logic              r_dma_rvalid;
  logic [DATA_W-1:0] r_cpu_rdata;
  logic [DATA_W-1:0] r_dma_rdata;

  logic [1:0]        w_pick;
  logic              w_cpu_gnt;
  logic              w_dma_gnt;
  logic              w_cpu_rd;
  logic              w_dma_rd;
  logic              w_release;
  logic [ADDR_W-1:0] w_mem_addr;
  logic [DATA_W-1:0] w_mem_wdata;

  dm_arb_rr_pick u_pick (
    .i_req ({bus.dma_req, bus.cpu_req}),
    .i_ptr (r_rr_ptr),
    .o_gnt (w_pick)
  );

  // While locked the DMA owns the memory outright; nothing is granted in reset.
  always_comb begin
    w_cpu_gnt = 1'b0;
    w_dma_gnt = 1'b0;
    if (rst_n) begin
      if (r_state == DMA_LOCK) begin
        w_dma_gnt = bus.dma_req;
      end else begin
        w_cpu_gnt = w_pick[0];
        w_dma_gnt = w_pick[1];
      end
    end
  end

  assign w_cpu_rd    = w_cpu_gnt & ~bus.cpu_we;
  assign w_dma_rd    = w_dma_gnt & ~bus.dma_we;
  assign w_release   = ~bus.dma_req | bus.dma_last | (r_beat_cnt == LAST_CNT);
  assign w_mem_addr  = w_dma_gnt ? bus.dma_addr  : bus.cpu_addr;
  assign w_mem_wdata = w_dma_gnt ? bus.dma_wdata : bus.cpu_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= FREE;
      r_beat_cnt   <= '0;
      r_rr_ptr     <= REQ_CPU;
      r_cpu_rvalid <= 1'b0;
      r_dma_rvalid <= 1'b0;
      r_cpu_rdata  <= '0;
      r_dma_rdata  <= '0;
    end else begin
      r_cpu_rvalid <= w_cpu_rd;
      r_dma_rvalid <= w_dma_rd;
      if (w_cpu_rd) r_cpu_rdata <= bus.mem_rdata;
      if (w_dma_rd) r_dma_rdata <= bus.mem_rdata;

      if (w_cpu_gnt)      r_rr_ptr <= REQ_DMA;
      else if (w_dma_gnt) r_rr_ptr <= REQ_CPU;

      case (r_state)
        FREE: begin
          if (BURST_EN && w_dma_gnt && !bus.dma_last) begin
            r_state    <= DMA_LOCK;
            r_beat_cnt <= CNT_W'(1);
          end
        end
        DMA_LOCK: begin
          // A pending CPU request gets the first FREE cycle after release.
          if (w_release) begin
            r_state    <= FREE;
            r_beat_cnt <= '0;
            r_rr_ptr   <= REQ_CPU;
          end else begin
            r_beat_cnt <= r_beat_cnt + CNT_W'(1);
          end
        end
        default: begin
          r_state    <= FREE;
          r_beat_cnt <= '0;
        end
      endcase
    end
  end

  assign bus.cpu_gnt    = w_cpu_gnt;
  assign bus.dma_gnt    = w_dma_gnt;
  assign bus.cpu_rvalid = r_cpu_rvalid;
  assign bus.dma_rvalid = r_dma_rvalid;
  assign bus.cpu_rdata  = r_cpu_rdata;
  assign bus.dma_rdata  = r_dma_rdata;
  assign bus.mem_we     = (w_cpu_gnt & bus.cpu_we) | (w_dma_gnt & bus.dma_we);
  assign bus.mem_addr   = w_mem_addr;
  assign bus.mem_wdata  = w_mem_wdata;

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter (MAX_BURST = 4) against a falling-edge-write memory model.
// Expectations adapt when DM_ARB_CPU_PRIORITY_EN is defined.
module tb_dm_arbiter;

`ifdef DM_ARB_CPU_PRIORITY_EN
  localparam bit P = 1'b1;
`else
  localparam bit P = 1'b0;
`endif

  localparam logic [31:0] DB   = 32'hDEADBEEF;
  localparam logic [31:0] R10  = 32'hA5000010;
  localparam logic [31:0] R20  = 32'hA5000020;
  localparam logic [31:0] R200 = 32'hA5000200;
  localparam logic [31:0] R201 = 32'hA5000201;
  localparam logic [31:0] R202 = 32'hA5000202;
  localparam logic [31:0] R203 = 32'hA5000203;
  localparam logic [31:0] R301 = 32'hA5000301;
  localparam logic [31:0] R302 = 32'hA5000302;
  localparam logic [31:0] B101 = 32'hB0000101;
  localparam logic [31:0] B103 = 32'hB0000103;
  localparam logic [31:0] C300 = 32'hC0000300;
  localparam logic [31:0] DD23 = P ? 32'hA5000203 : 32'hA5000204;
  localparam logic [31:0] DD24 = P ? 32'hA5000203 : 32'hA5000205;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dm_arbiter_if #(.ADDR_W(10), .DATA_W(32)) bus ();

  dm_arbiter #(.ADDR_W(10), .DATA_W(32), .MAX_BURST(4)) u_dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Unwritten words read back as A500_0000 | address.
  logic [31:0] mem   [1024];
  logic        r_vld [1024];
  always @(negedge clk)
    if (bus.mem_we) begin
      mem[bus.mem_addr]   <= bus.mem_wdata;
      r_vld[bus.mem_addr] <= 1'b1;
    end
  assign bus.mem_rdata = (r_vld[bus.mem_addr] === 1'b1) ? mem[bus.mem_addr]
                                                         : (32'hA5000000 | {22'd0, bus.mem_addr});

  typedef struct {
    logic        rst;
    logic        creq, cwe;
    logic [9:0]  caddr;
    logic [31:0] cwd;
    logic        dreq, dwe;
    logic [9:0]  daddr;
    logic [31:0] dwd;
    logic        dlast;
    logic        ecg, edg, ewe, ecv, edv;
    logic [31:0] ecd, edd;
  } vec_t;

  vec_t tbl[$];
  int   n_checks = 0;
  int   n_errors = 0;

  function automatic vec_t mk(logic rst, logic creq, logic cwe, logic [9:0] caddr, logic [31:0] cwd,
                              logic dreq, logic dwe, logic [9:0] daddr, logic [31:0] dwd, logic dlast,
                              logic ecg, logic edg, logic ewe, logic ecv, logic edv,
                              logic [31:0] ecd, logic [31:0] edd);
    vec_t v;
    v.rst = rst; v.creq = creq; v.cwe = cwe; v.caddr = caddr; v.cwd = cwd;
    v.dreq = dreq; v.dwe = dwe; v.daddr = daddr; v.dwd = dwd; v.dlast = dlast;
    v.ecg = ecg; v.edg = edg; v.ewe = ewe; v.ecv = ecv; v.edv = edv;
    v.ecd = ecd; v.edd = edd;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v);
    rst_n         = v.rst;
    bus.cpu_req   = v.creq;
    bus.cpu_we    = v.cwe;
    bus.cpu_addr  = v.caddr;
    bus.cpu_wdata = v.cwd;
    bus.dma_req   = v.dreq;
    bus.dma_we    = v.dwe;
    bus.dma_addr  = v.daddr;
    bus.dma_wdata = v.dwd;
    bus.dma_last  = v.dlast;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  dbeats;
    bit  got;
    vec_t idle;

    idle = mk(1,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0);
    idle.rst = 1'b0;
    drive(idle);

    //                rst cpu:req we addr  wdata       dma:req we addr  wdata       last | cg  dg  we  cv  dv  cd    dd
    tbl.push_back(mk(0, 1,1,10'h005,DB,           1,0,10'h020,0,           1,  0,  0,  0,  0,  0,  0,    0));
    tbl.push_back(mk(1, 1,1,10'h005,DB,           0,0,10'h000,0,           0,  1,  0,  1,  0,  0,  0,    0));
    tbl.push_back(mk(1, 1,0,10'h005,0,            0,0,10'h000,0,           0,  1,  0,  0,  0,  0,  0,    0));
    tbl.push_back(mk(1, 0,0,10'h000,0,            0,0,10'h000,0,           0,  0,  0,  0,  1,  0,  DB,   0));
    tbl.push_back(mk(1, 0,0,10'h000,0,            1,0,10'h020,0,           1,  0,  1,  0,  0,  0,  DB,   0));
    tbl.push_back(mk(1, 1,0,10'h010,0,            1,0,10'h020,0,           1,  1,  0,  0,  0,  1,  DB,   R20));
    tbl.push_back(mk(1, 1,0,10'h010,0,            1,0,10'h020,0,           1,  P,  !P, 0,  1,  0,  R10,  R20));
    tbl.push_back(mk(1, 1,0,10'h010,0,            1,0,10'h020,0,           1,  1,  0,  0,  P,  !P, R10,  R20));
    tbl.push_back(mk(1, 1,0,10'h010,0,            1,0,10'h020,0,           1,  P,  !P, 0,  1,  0,  R10,  R20));
    tbl.push_back(mk(1, 0,0,10'h000,0,            0,0,10'h000,0,           0,  0,  0,  0,  P,  !P, R10,  R20));
    tbl.push_back(mk(1, 0,0,10'h000,0,            1,1,10'h100,32'hB0000100,0,  0,  1,  1,  0,  0,  R10,  R20));
    tbl.push_back(mk(1, 1,0,10'h101,0,            1,1,10'h101,32'hB0000101,0,  0,  1,  1,  0,  0,  R10,  R20));
    tbl.push_back(mk(1, 1,0,10'h101,0,            1,1,10'h102,32'hB0000102,0,  0,  1,  1,  0,  0,  R10,  R20));
    tbl.push_back(mk(1, 1,0,10'h101,0,            1,1,10'h103,32'hB0000103,1,  0,  1,  1,  0,  0,  R10,  R20));
    tbl.push_back(mk(1, 1,0,10'h101,0,            0,0,10'h000,0,           0,  1,  0,  0,  0,  0,  R10,  R20));
    tbl.push_back(mk(1, 0,0,10'h000,0,            1,0,10'h103,0,           1,  0,  1,  0,  1,  0,  B101, R20));
    tbl.push_back(mk(1, 0,0,10'h000,0,            0,0,10'h000,0,           0,  0,  0,  0,  0,  1,  B101, B103));
    tbl.push_back(mk(1, 0,0,10'h000,0,            1,0,10'h200,0,           0,  0,  1,  0,  0,  0,  B101, B103));
    tbl.push_back(mk(1, 1,0,10'h010,0,            1,0,10'h201,0,           0,  0,  1,  0,  0,  1,  B101, R200));
    tbl.push_back(mk(1, 1,0,10'h010,0,            1,0,10'h202,0,           0,  0,  1,  0,  0,  1,  B101, R201));
    tbl.push_back(mk(1, 1,0,10'h010,0,            1,0,10'h203,0,           0,  0,  1,  0,  0,  1,  B101, R202));
    tbl.push_back(mk(1, 1,0,10'h010,0,            1,0,10'h204,0,           0,  1,  0,  0,  0,  1,  B101, R203));
    tbl.push_back(mk(1, 1,0,10'h010,0,            1,0,10'h204,0,           0,  P,  !P, 0,  1,  0,  R10,  R203));
    tbl.push_back(mk(1, 1,0,10'h010,0,            1,0,10'h205,0,           0,  P,  !P, 0,  P,  !P, R10,  DD23));
    tbl.push_back(mk(1, 0,0,10'h000,0,            0,0,10'h000,0,           0,  0,  0,  0,  P,  !P, R10,  DD24));
    tbl.push_back(mk(1, 1,0,10'h010,0,            1,0,10'h030,0,           1,  1,  0,  0,  0,  0,  R10,  DD24));
    tbl.push_back(mk(1, 0,0,10'h000,0,            0,0,10'h000,0,           0,  0,  0,  0,  1,  0,  R10,  DD24));
    tbl.push_back(mk(1, 0,0,10'h000,0,            1,1,10'h300,C300,        0,  0,  1,  1,  0,  0,  R10,  DD24));
    tbl.push_back(mk(1, 1,0,10'h010,0,            1,0,10'h301,0,           0,  0,  1,  0,  0,  0,  R10,  DD24));
    tbl.push_back(mk(0, 1,0,10'h010,0,            1,1,10'h302,32'hC0000302,0,  0,  0,  0,  0,  1,  R10,  R301));
    tbl.push_back(mk(1, 1,0,10'h010,0,            1,1,10'h302,32'hC0000302,0,  1,  0,  0,  0,  0,  0,    0));
    tbl.push_back(mk(1, 0,0,10'h000,0,            1,0,10'h302,0,           1,  0,  1,  0,  1,  0,  R10,  0));
    tbl.push_back(mk(1, 0,0,10'h000,0,            0,0,10'h000,0,           0,  0,  0,  0,  0,  1,  R10,  R302));
    tbl.push_back(mk(1, 1,0,10'h300,0,            0,0,10'h000,0,           0,  1,  0,  0,  0,  0,  R10,  R302));
    tbl.push_back(mk(1, 0,0,10'h000,0,            0,0,10'h000,0,           0,  0,  0,  0,  1,  0,  C300, R302));

    repeat (2) @(posedge clk);

    foreach (tbl[i]) begin
      @(posedge clk); #1;
      drive(tbl[i]);
      #2;
      chk($sformatf("row%0d cpu_gnt", i),    {31'd0, bus.cpu_gnt},    {31'd0, tbl[i].ecg});
      chk($sformatf("row%0d dma_gnt", i),    {31'd0, bus.dma_gnt},    {31'd0, tbl[i].edg});
      chk($sformatf("row%0d mem_we", i),     {31'd0, bus.mem_we},     {31'd0, tbl[i].ewe});
      chk($sformatf("row%0d cpu_rvalid", i), {31'd0, bus.cpu_rvalid}, {31'd0, tbl[i].ecv});
      chk($sformatf("row%0d dma_rvalid", i), {31'd0, bus.dma_rvalid}, {31'd0, tbl[i].edv});
      chk($sformatf("row%0d cpu_rdata", i),  bus.cpu_rdata,           tbl[i].ecd);
      chk($sformatf("row%0d dma_rdata", i),  bus.dma_rdata,           tbl[i].edd);
      if (tbl[i].ecg || tbl[i].edg)
        chk($sformatf("row%0d mem_addr", i), {22'd0, bus.mem_addr},
            {22'd0, tbl[i].edg ? tbl[i].daddr : tbl[i].caddr});
    end

    // Unterminated DMA burst with the CPU waiting: lock caps at 4 beats, then the CPU gets a turn.
    dbeats = 0;
    got    = 1'b0;
    for (int c = 0; c < 16 && !got; c++) begin
      @(posedge clk); #1;
      rst_n        = 1'b1;
      bus.cpu_req  = (c > 0);
      bus.cpu_we   = 1'b0;
      bus.cpu_addr = 10'h011;
      bus.dma_req  = 1'b1;
      bus.dma_we   = 1'b0;
      bus.dma_addr = 10'(32'h40 + dbeats);
      bus.dma_last = 1'b0;
      #2;
      if (bus.cpu_gnt) got = 1'b1;
      else if (bus.dma_gnt) dbeats++;
    end
    chk("cap cpu granted", {31'd0, got}, 32'd1);
    chk("cap dma beats", dbeats, 32'd4);

    @(posedge clk); #1;
    bus.dma_addr = 10'h044;
    #2;
    chk("after cap dma_gnt", {31'd0, bus.dma_gnt}, {31'd0, !P});
    chk("after cap cpu_gnt", {31'd0, bus.cpu_gnt}, {31'd0, P});
    chk("after cap cpu_rvalid", {31'd0, bus.cpu_rvalid}, 32'd1);
    chk("after cap cpu_rdata", bus.cpu_rdata, 32'hA5000011);

    @(posedge clk); #1;
    drive(mk(1,0,0,0,0, 0,0,0,0,0, 0,0,0,0,0, 0,0));
    #2;
    chk("tail dma_rvalid", {31'd0, bus.dma_rvalid}, {31'd0, !P});

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
